tetris_cmd_source: RTL and testbench
====================================

Name: tetris_cmd_source

Overview:
- Producer/writer side of the game command queue.
- Turns player inputs and gravity/garbage timers into state_type commands: push-buttons (edge-detected) and UART key bytes (decoded), plus free-running DOWN and BAR timers.
- Arbitrates these sources into a QSIZE-deep FIFO.
- The game FSM pops the FIFO through a valid/ready handshake.

Parameters:
- QSIZE, 16, FIFO depth in entries; power of two, ≥2.
- DOWN_TICK, 50_000_000, clk cycles between automatic DOWN commands.
- BAR_TICK, 500_000_000, clk cycles between automatic BAR commands.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- running  in  1  game active; timers count only while high.
- flush  in  1  synchronous clear of FIFO, pending bits and timers.
- btn  in  4  debounced levels: [0] LEFT, [1] RIGHT, [2] ROTATE, [3] DROP.
- rx_valid  in  1  one-cycle strobe: UART byte received.
- rx_data  in  8  UART byte.
- cmd  out  8  FIFO head as state_type; NONE when empty.
- cmd_valid  out  1  FIFO non-empty.
- cmd_ready  in  1  consumer pops head when cmd_valid && cmd_ready.
- count  out  $clog2(QSIZE)+1  entries held.
- drop_cnt  out  8  saturating count of coalesced (lost) events.

Behaviour:
- Async reset: FIFO empty, cmd=NONE, cmd_valid=0, count=0, drop_cnt=0, pending bits clear, timers 0, btn history 0.
- Button events: each btn bit is rising-edge detected against its registered previous value (0→1). Any high bit at the first clock after reset counts as an event.
- UART decode, on rx_valid:
  - 'a'/'A'→LEFT, 'd'/'D'→RIGHT, 's'/'S'→DOWN, ' '→DROP, 'w'/'W'→ROTATE, 'q'/'Q'→ROTATE_REV, 'c'/'C'→HOLD.
  - Any other byte is ignored and not counted.
- DOWN timer: while running && !flush, counts 0..DOWN_TICK-1. Reaching DOWN_TICK-1 raises a DOWN event and the timer wraps to 0. While running=0 it holds its value.
- BAR timer: same scheme with BAR_TICK; raises a BAR event.
- Pending slots: seven, one per source (BAR timer, UART, btn0..3, DOWN timer).
  - An event sets its slot at the clock edge where it is detected. The UART slot also latches the decoded command.
  - An event arriving while its slot is already set is lost. drop_cnt increments, saturating at 255.
  - If several events on different slots arrive in the same cycle, all are captured.
- Arbiter: at most one push per cycle. Fixed priority BAR > UART > btn0 > btn1 > btn2 > btn3 > DOWN timer.
  - A push happens only if the FIFO has room after this cycle's pop: count<QSIZE, or a pop occurs the same cycle.
  - The pushed slot clears on the same edge. A slot may clear and be re-set on the same edge only if a new event arrives; the new event is kept, not counted as a drop.
- Latency: event detected at edge t → pushed at edge t+1 if it wins arbitration → cmd/cmd_valid reflect it after t+1 when the FIFO was empty.
- FIFO: first-word-fall-through.
  - cmd is driven from mem[rd_ptr] when count≠0, else NONE.
  - Pointers are $clog2(QSIZE) bits wide and wrap naturally.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Full FIFO: pending slots hold, giving backpressure rather than loss. Loss occurs only via coalescing.
- Pop when empty: ignored.
- flush (synchronous, highest precedence):
  - FIFO emptied, pending slots cleared, timers zeroed, drop_cnt kept.
  - Events and pops in the flush cycle are discarded.

Test Plan:
- Reset, then btn=4'b0001 at one cycle, cmd_ready=0 → after 2 edges cmd=LEFT, cmd_valid=1, count=1; holding btn high adds nothing more.
- rx_valid with 'w', then 'x', then 'C' on separate cycles → FIFO holds ROTATE, HOLD in order; 'x' ignored; drop_cnt=0.
- Same-cycle BAR timer expiry, UART 'a' and btn=4'b1010 (DOWN_TICK=8, BAR_TICK=8, cmd_ready=0) → pushes over successive cycles in order BAR, LEFT, RIGHT, DROP, then DOWN.
- Fill to 16 with cmd_ready=0 while running → count saturates at 16. A second UART key while the UART slot is pending → drop_cnt=1. Raising cmd_ready → pending entries enter as space frees, with count staying 16 until pending drain.
- running=0 for 100 cycles mid-count → no DOWN events; timer resumes from the held value (DOWN_TICK=20: next DOWN after the remaining cycles only).
- Queue with 5 entries plus pending btn, assert flush for 1 cycle → cmd=NONE, cmd_valid=0, count=0 next cycle, no late push; async reset_n pulse mid-stream → all outputs at reset values immediately.

Source files
------------

// File: rtl/tetris_cmd_source.sv
`default_nettype none
// ============================================================================
// Module      : tetris_cmd_source
// Description : Writer side of the game command queue. Converts push-button
//               rising edges, decoded UART key bytes and two free-running
//               timers (DOWN gravity, BAR garbage) into command bytes.
//               Each source owns one pending slot. A fixed-priority arbiter
//               moves at most one slot per cycle into a first-word-fall-
//               through FIFO that the game FSM pops via valid/ready.
//
// Ports       : clk        system clock
//               reset_n    asynchronous active-low reset
//               running    game active; timers advance only while high
//               flush      synchronous clear of FIFO, slots and timers
//               btn[3:0]   debounced levels: LEFT, RIGHT, ROTATE, DROP
//               rx_valid   one-cycle strobe, UART byte received
//               rx_data    UART byte
//               cmd        FIFO head command (NONE when empty)
//               cmd_valid  FIFO non-empty
//               cmd_ready  consumer pops head when cmd_valid && cmd_ready
//               count      entries held in the FIFO
//               drop_cnt   saturating count of coalesced (lost) events
//
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_cmd_source #(
    parameter int QSIZE     = 16,
    parameter int DOWN_TICK = 50_000_000,
    parameter int BAR_TICK  = 500_000_000,
    localparam int AW       = $clog2(QSIZE),
    localparam int CW       = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          running,
    input  logic          flush,
    input  logic [3:0]    btn,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic [7:0]    cmd,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [CW-1:0] count,
    output logic [7:0]    drop_cnt
);

    // ------------------------------------------------------------------
    // Command encoding (state_type values shared with the game FSM)
    // ------------------------------------------------------------------
    localparam logic [7:0] CMD_NONE       = 8'd0;
    localparam logic [7:0] CMD_LEFT       = 8'd1;
    localparam logic [7:0] CMD_RIGHT      = 8'd2;
    localparam logic [7:0] CMD_DOWN       = 8'd3;
    localparam logic [7:0] CMD_DROP       = 8'd4;
    localparam logic [7:0] CMD_ROTATE     = 8'd5;
    localparam logic [7:0] CMD_ROTATE_REV = 8'd6;
    localparam logic [7:0] CMD_HOLD       = 8'd7;
    localparam logic [7:0] CMD_BAR        = 8'd8;

    // Slot indices; lower index wins arbitration.
    localparam int NSLOT     = 7;
    localparam int SLOT_BAR  = 0;
    localparam int SLOT_UART = 1;
    localparam int SLOT_BTN0 = 2;
    localparam int SLOT_DOWN = 6;

    localparam logic [31:0]   DOWN_LAST = 32'(DOWN_TICK - 1);
    localparam logic [31:0]   BAR_LAST  = 32'(BAR_TICK - 1);
    localparam logic [CW-1:0] QFULL     = CW'(QSIZE);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]       btn_prev_q;
    logic [31:0]      down_tmr_q, down_tmr_d;
    logic [31:0]      bar_tmr_q,  bar_tmr_d;
    logic [NSLOT-1:0] pend_q,     pend_d;
    logic [7:0]       uart_cmd_q, uart_cmd_d;
    logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]    count_q,    count_d;
    logic [7:0]       drop_q,     drop_d;
    logic [7:0]       mem_q [QSIZE];

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    logic [3:0]       btn_rise;
    logic             uart_hit;
    logic [7:0]       uart_dec;
    logic             down_evt;
    logic             bar_evt;
    logic [NSLOT-1:0] evt;

    assign btn_rise = btn & ~btn_prev_q;
    assign down_evt = running && (down_tmr_q == DOWN_LAST);
    assign bar_evt  = running && (bar_tmr_q == BAR_LAST);

    always_comb begin
        uart_hit = 1'b0;
        uart_dec = CMD_NONE;
        if (rx_valid) begin
            uart_hit = 1'b1;
            case (rx_data)
                8'h61, 8'h41: uart_dec = CMD_LEFT;        // a / A
                8'h64, 8'h44: uart_dec = CMD_RIGHT;       // d / D
                8'h73, 8'h53: uart_dec = CMD_DOWN;        // s / S
                8'h20:        uart_dec = CMD_DROP;        // space
                8'h77, 8'h57: uart_dec = CMD_ROTATE;      // w / W
                8'h71, 8'h51: uart_dec = CMD_ROTATE_REV;  // q / Q
                8'h63, 8'h43: uart_dec = CMD_HOLD;        // c / C
                default:      uart_hit = 1'b0;
            endcase
        end
    end

    assign evt = {down_evt, btn_rise, uart_hit, bar_evt};

    // ------------------------------------------------------------------
    // Timers: wrap to 0 on the edge that raises their event
    // ------------------------------------------------------------------
    always_comb begin
        down_tmr_d = down_tmr_q;
        bar_tmr_d  = bar_tmr_q;
        if (flush) begin
            down_tmr_d = '0;
            bar_tmr_d  = '0;
        end else if (running) begin
            down_tmr_d = (down_tmr_q == DOWN_LAST) ? '0 : down_tmr_q + 32'd1;
            bar_tmr_d  = (bar_tmr_q == BAR_LAST)   ? '0 : bar_tmr_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO handshake and arbitration
    // ------------------------------------------------------------------
    logic             pop;
    logic             room;
    logic [NSLOT-1:0] grant;
    logic             push;
    logic [7:0]       push_data;

    assign pop  = (count_q != '0) && cmd_ready;
    // Room exists if not full now, or the head leaves on this same edge.
    assign room = (count_q < QFULL) || pop;

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (pend_q[i] && !found && room) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign push = |grant;

    always_comb begin
        push_data = CMD_NONE;
        unique case (1'b1)
            grant[SLOT_BAR]:      push_data = CMD_BAR;
            grant[SLOT_UART]:     push_data = uart_cmd_q;
            grant[SLOT_BTN0]:     push_data = CMD_LEFT;
            grant[SLOT_BTN0 + 1]: push_data = CMD_RIGHT;
            grant[SLOT_BTN0 + 2]: push_data = CMD_ROTATE;
            grant[SLOT_BTN0 + 3]: push_data = CMD_DROP;
            grant[SLOT_DOWN]:     push_data = CMD_DOWN;
            default:              push_data = CMD_NONE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pending slots and drop accounting
    // ------------------------------------------------------------------
    // A slot that stays set (not granted) swallows any new event for it.
    logic [NSLOT-1:0] held;
    logic [NSLOT-1:0] drop_vec;
    logic [2:0]       ndrop;
    logic [8:0]       drop_sum;

    assign held     = pend_q & ~grant;
    assign drop_vec = evt & held;

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NSLOT; i++) begin
            ndrop = ndrop + {2'b00, drop_vec[i]};
        end
    end

    assign drop_sum = {1'b0, drop_q} + {6'd0, ndrop};

    always_comb begin
        pend_d     = held | evt;
        uart_cmd_d = uart_cmd_q;
        drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        // A coalesced UART key must not overwrite the command still waiting.
        if (uart_hit && !held[SLOT_UART]) begin
            uart_cmd_d = uart_dec;
        end
        if (flush) begin
            pend_d = '0;
            drop_d = drop_q;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev_q <= '0;
            down_tmr_q <= '0;
            bar_tmr_q  <= '0;
            pend_q     <= '0;
            uart_cmd_q <= CMD_NONE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
        end else begin
            btn_prev_q <= btn;
            down_tmr_q <= down_tmr_d;
            bar_tmr_q  <= bar_tmr_d;
            pend_q     <= pend_d;
            uart_cmd_q <= uart_cmd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end

    // Storage array carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_valid = (count_q != '0);
    assign cmd       = cmd_valid ? mem_q[rd_ptr_q] : CMD_NONE;
    assign count     = count_q;
    assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_tetris_cmd_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_tetris_cmd_source
// Description : Directed self-checking bench for tetris_cmd_source. DUT A
//               (DOWN_TICK=8, BAR_TICK=8) covers most scenarios; DUT B
//               (DOWN_TICK=20) covers timer hold while running is low.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tetris_cmd_source;

    localparam logic [7:0] NONE   = 8'd0;
    localparam logic [7:0] LEFT   = 8'd1;
    localparam logic [7:0] RIGHT  = 8'd2;
    localparam logic [7:0] DOWN   = 8'd3;
    localparam logic [7:0] DROP   = 8'd4;
    localparam logic [7:0] ROTATE = 8'd5;
    localparam logic [7:0] HOLD   = 8'd7;
    localparam logic [7:0] BAR    = 8'd8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       running;
    logic       flush;
    logic [3:0] btn;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cmd_ready;

    logic [7:0] cmd_a, cmd_b, drop_a, drop_b;
    logic       valid_a, valid_b;
    logic [4:0] count_a, count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tetris_cmd_source #(.QSIZE(16), .DOWN_TICK(8), .BAR_TICK(8)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .running(running), .flush(flush),
        .btn(btn), .rx_valid(rx_valid), .rx_data(rx_data),
        .cmd(cmd_a), .cmd_valid(valid_a), .cmd_ready(cmd_ready),
        .count(count_a), .drop_cnt(drop_a)
    );

    tetris_cmd_source #(.QSIZE(16), .DOWN_TICK(20), .BAR_TICK(1000)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .running(running), .flush(flush),
        .btn(btn), .rx_valid(rx_valid), .rx_data(rx_data),
        .cmd(cmd_b), .cmd_valid(valid_b), .cmd_ready(cmd_ready),
        .count(count_b), .drop_cnt(drop_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic uart(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // One rising edge on btn0 per call; push lands on the second edge.
    task automatic btn0_pulse();
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        tick();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; running = 1'b0; flush = 1'b0; btn = 4'b0000;
        rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b0;
        #3;
        chk("rst_cmd",   32'(cmd_a),   32'(NONE));
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_drop",  32'(drop_a),  32'd0);
        #9;
        reset_n = 1'b1;

        // ---- button edge detect ----
        btn = 4'b0001;
        tick();
        chk("btn_lat_count", 32'(count_a), 32'd0);
        tick();
        chk("btn_cmd",   32'(cmd_a),   32'(LEFT));
        chk("btn_valid", 32'(valid_a), 32'd1);
        chk("btn_count", 32'(count_a), 32'd1);
        ticks(4);
        chk("btn_hold_count", 32'(count_a), 32'd1);
        btn = 4'b0000;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("btn_pop_count", 32'(count_a), 32'd0);
        chk("btn_pop_cmd",   32'(cmd_a),   32'(NONE));

        // ---- UART decode ----
        uart("w");
        uart("x");
        uart("C");
        ticks(2);
        chk("uart_count", 32'(count_a), 32'd2);
        chk("uart_head",  32'(cmd_a),   32'(ROTATE));
        chk("uart_drop",  32'(drop_a),  32'd0);
        cmd_ready = 1'b1;
        tick();
        chk("uart_second", 32'(cmd_a),   32'(HOLD));
        chk("uart_cnt1",   32'(count_a), 32'd1);
        tick();
        cmd_ready = 1'b0;
        chk("uart_empty", 32'(count_a), 32'd0);

        // ---- same-cycle events, priority order ----
        running = 1'b1;
        ticks(7);
        rx_valid = 1'b1; rx_data = "a"; btn = 4'b1010;
        tick();
        rx_valid = 1'b0; running = 1'b0;
        chk("prio_pend_count", 32'(count_a), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("prio_count", 32'(count_a), 32'(i));
        end
        chk("prio_head", 32'(cmd_a), 32'(BAR));
        btn = 4'b0000;
        cmd_ready = 1'b1;
        begin
            logic [7:0] exp_seq [5];
            exp_seq = '{BAR, LEFT, RIGHT, DROP, DOWN};
            for (int i = 0; i < 5; i++) begin
                chk("prio_order", 32'(cmd_a), 32'(exp_seq[i]));
                tick();
            end
        end
        cmd_ready = 1'b0;
        chk("prio_empty", 32'(count_a), 32'd0);

        // ---- fill, backpressure, coalescing ----
        for (int i = 0; i < 16; i++) btn0_pulse();
        chk("full_count", 32'(count_a), 32'd16);
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        chk("full_hold", 32'(count_a), 32'd16);
        uart("s");
        uart("d");
        tick();
        chk("full_count2", 32'(count_a), 32'd16);
        chk("coalesce_drop", 32'(drop_a), 32'd1);
        cmd_ready = 1'b1;
        tick();
        chk("drain_c1", 32'(count_a), 32'd16);
        tick();
        chk("drain_c2", 32'(count_a), 32'd16);
        tick();
        chk("drain_c3", 32'(count_a), 32'd15);
        ticks(13);
        chk("drain_c4",   32'(count_a), 32'd2);
        chk("drain_uart", 32'(cmd_a),   32'(DOWN));
        tick();
        chk("drain_btn",  32'(cmd_a),   32'(LEFT));
        tick();
        cmd_ready = 1'b0;
        chk("drain_empty", 32'(count_a), 32'd0);

        // ---- timer hold while running low (DUT B) ----
        do_flush();
        running = 1'b1;
        ticks(10);
        running = 1'b0;
        ticks(100);
        chk("pause_none", 32'(count_b), 32'd0);
        running = 1'b1;
        ticks(9);
        chk("resume_early", 32'(count_b), 32'd0);
        tick();
        running = 1'b0;
        chk("resume_pend", 32'(count_b), 32'd0);
        tick();
        chk("resume_count", 32'(count_b), 32'd1);
        chk("resume_cmd",   32'(cmd_b),   32'(DOWN));

        // ---- flush (DUT A) ----
        do_flush();
        chk("flush0_count", 32'(count_a), 32'd0);
        for (int i = 0; i < 5; i++) btn0_pulse();
        btn = 4'b0010;
        tick();
        chk("preflush_count", 32'(count_a), 32'd5);
        flush = 1'b1; cmd_ready = 1'b1; rx_valid = 1'b1; rx_data = "a";
        tick();
        flush = 1'b0; cmd_ready = 1'b0; rx_valid = 1'b0;
        chk("flush_cmd",   32'(cmd_a),   32'(NONE));
        chk("flush_valid", 32'(valid_a), 32'd0);
        chk("flush_count", 32'(count_a), 32'd0);
        chk("flush_drop",  32'(drop_a),  32'd1);
        ticks(2);
        chk("flush_late", 32'(count_a), 32'd0);
        btn = 4'b0000;
        tick();

        // ---- asynchronous reset mid-stream ----
        btn0_pulse();
        chk("pre_rst_count", 32'(count_a), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_cmd",   32'(cmd_a),   32'(NONE));
        chk("arst_valid", 32'(valid_a), 32'd0);
        chk("arst_count", 32'(count_a), 32'd0);
        chk("arst_drop",  32'(drop_a),  32'd0);
        #3;
        reset_n = 1'b1;
        ticks(2);
        chk("post_rst_count", 32'(count_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
